// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Instruction fetch control for the pipeline front end. Owns the PC, issues
//   one request at a time to instruction memory, and parks each returned word
//   in a registered output slot until decode accepts it. Branch redirects
//   may arrive in any state. A response that belongs to a redirected-away
//   request is never shown to decode.
//
//   Optional statistics: define FETCH_STATS_EN to add the fetch_count and
//   stall_cycles ports. Without the macro the block has no extra ports and
//   behaves identically.
//
// Parameters
//   ADDR_W    PC / memory address width
//   DATA_W    instruction width
//   RESET_PC  first fetch address after reset
//   PC_STEP   PC increment per sequential fetch (wraps modulo 2^ADDR_W)
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous reset, active-high
//   imem_req_valid  fetch request valid                      (registered)
//   imem_req_ready  memory accepts request this cycle
//   imem_req_addr   fetch address                            (registered)
//   imem_rsp_valid  response valid, single-cycle pulse
//   imem_rsp_data   response instruction word
//   redirect_valid  branch/jump redirect, single-cycle pulse
//   redirect_pc     redirect target, used as-is
//   out_valid       instruction available to decode         (registered)
//   out_ready       decode accepts instruction
//   out_instr       held instruction                         (registered)
//   out_pc          PC of out_instr                          (registered)
//   fetch_count     [FETCH_STATS_EN] instructions delivered, saturating
//   stall_cycles    [FETCH_STATS_EN] cycles held by decode, saturating
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int unsigned CNT_W = 16;

  // REQ: request presented; WAIT: one request in flight; HOLD: word parked
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              drop_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_instr_q;
  logic [ADDR_W-1:0] out_pc_q;

  logic              req_fire_c;
  logic              deliver_c;
  logic [ADDR_W-1:0] pc_inc_c;

  // Request handshake only counts while the request is actually presented
  assign req_fire_c = (state_q == ST_REQ) && req_valid_q && imem_req_ready;
  assign deliver_c  = out_valid_q && out_ready;
  assign pc_inc_c   = pc_q + ADDR_W'(PC_STEP);

  // Fetch FSM with its registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over everything: retarget the PC and discard the held word
      pc_q        <= redirect_pc;
      out_valid_q <= 1'b0;
      case (state_q)
        ST_REQ: begin
          if (req_fire_c) begin
            // Memory already took the old address; its response must be dropped
            state_q     <= ST_WAIT;
            req_valid_q <= 1'b0;
            drop_q      <= 1'b1;
          end else begin
            req_valid_q <= 1'b1;
            req_addr_q  <= redirect_pc;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            // Response for the stale address arrives now: swallow it here
            state_q     <= ST_REQ;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b1;
            req_addr_q  <= redirect_pc;
          end else begin
            drop_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          state_q     <= ST_REQ;
          req_valid_q <= 1'b1;
          req_addr_q  <= redirect_pc;
        end
        default: begin
          state_q     <= ST_REQ;
          drop_q      <= 1'b0;
          req_valid_q <= 1'b1;
          req_addr_q  <= redirect_pc;
        end
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (req_fire_c) begin
            state_q     <= ST_WAIT;
            req_valid_q <= 1'b0;
          end else begin
            // Also raises valid on the first cycle after reset
            req_valid_q <= 1'b1;
            req_addr_q  <= pc_q;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              state_q     <= ST_REQ;
              drop_q      <= 1'b0;
              req_valid_q <= 1'b1;
              req_addr_q  <= pc_q;
            end else begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
              out_instr_q <= imem_rsp_data;
              out_pc_q    <= pc_q;
              pc_q        <= pc_inc_c;
            end
          end
        end
        ST_HOLD: begin
          if (deliver_c) begin
            // Next request goes out on the following cycle; no prefetch
            state_q     <= ST_REQ;
            out_valid_q <= 1'b0;
            req_valid_q <= 1'b1;
            req_addr_q  <= pc_q;
          end
        end
        default: begin
          state_q     <= ST_REQ;
          drop_q      <= 1'b0;
          out_valid_q <= 1'b0;
          req_valid_q <= 1'b1;
          req_addr_q  <= pc_q;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign out_valid      = out_valid_q;
  assign out_instr      = out_instr_q;
  assign out_pc         = out_pc_q;

`ifdef FETCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] fetch_count_q;
  logic [CNT_W-1:0] fetch_count_d;
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;

  // Saturating event counters observed on the decode handshake
  always_comb begin
    fetch_count_d  = fetch_count_q;
    stall_cycles_d = stall_cycles_q;
    if (deliver_c && (fetch_count_q != CNT_MAX)) begin
      fetch_count_d = fetch_count_q + CNT_W'(1);
    end
    if (out_valid_q && !out_ready && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign stall_cycles = stall_cycles_q;
`else
  // Counter width unused when statistics are compiled out
  localparam int unsigned UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Cycle table for the basic fetch / backpressure / redirect cases, directed
//   sequences for redirect-in-HOLD, PC wrap, mid-transaction reset and the
//   optional counters, then random traffic against a transaction-level model
//   (expected next PC + memory contents).
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count), .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
    logic        ordy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rsp, input logic [31:0] data,
                              input logic redir, input logic [31:0] rpc, input logic ordy,
                              input logic e_rv, input logic [31:0] e_addr, input logic e_ov,
                              input logic [31:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.rdy = rdy; v.rsp = rsp; v.data = data; v.redir = redir; v.rpc = rpc; v.ordy = ordy;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  // Instruction memory contents as a function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

`ifdef FETCH_STATS_EN
  // Fetch one word, then hold it for 'stalls' cycles before decode takes it
  task automatic deliver(input int stalls, input logic [31:0] data);
    int g;
    g = 0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    while (!imem_req_valid && g < 8) begin
      tick();
      g++;
    end
    chk("stats_req_wait", 32'(g < 8), 32'd1);
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    repeat (stalls) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] exp_next;
    logic [31:0] paddr;
    logic        pending;
    logic        pend0;
    int          lat;
    int          deliveries;
    logic        p_rv, p_ov;
    logic [31:0] p_addr, p_pc, p_instr;
    logic        c_rdy, c_ordy, c_redir, c_rsp;
    logic [31:0] c_rpc;

    rst = 1'b1;
    idle_inputs();

    // ---------------- cycle table, starting right after reset ----------------
    tbl.push_back(mk(1,0,32'h0,0,32'h0,1, 1,32'h0,  0,32'h0,32'h0));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,1, 0,32'h0,  0,32'h0,32'h0));
    tbl.push_back(mk(1,1,32'h1111_1111,0,32'h0,1, 0,32'h0, 1,32'h0,32'h1111_1111));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,1, 1,32'h4,  0,32'h0,32'h0));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,0, 0,32'h0,  0,32'h0,32'h0));
    tbl.push_back(mk(1,1,32'hDEAD_BEEF,0,32'h0,0, 0,32'h0, 1,32'h4,32'hDEAD_BEEF));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,0,32'h0,0,32'h0,0, 0,32'h0, 1,32'h4,32'hDEAD_BEEF));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,1, 1,32'h8,  0,32'h0,32'h0));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,1, 0,32'h0,  0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,32'h100,1, 0,32'h0, 0,32'h0,32'h0));
    tbl.push_back(mk(0,1,32'h8888_8888,0,32'h0,1, 1,32'h100, 0,32'h0,32'h0));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,1, 0,32'h0,  0,32'h0,32'h0));
    tbl.push_back(mk(0,1,32'h1001_0010,0,32'h0,1, 0,32'h0, 1,32'h100,32'h1001_0010));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'h104, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,32'h200,1, 1,32'h200, 0,32'h0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,32'h300,1, 0,32'h0, 0,32'h0,32'h0));
    tbl.push_back(mk(0,1,32'hDEAD_DEAD,0,32'h0,1, 1,32'h300, 0,32'h0,32'h0));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,1, 0,32'h0,  0,32'h0,32'h0));
    tbl.push_back(mk(0,1,32'h3030_3030,0,32'h0,1, 0,32'h0, 1,32'h300,32'h3030_3030));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'h304, 0,32'h0,32'h0));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,1, 0,32'h0,  0,32'h0,32'h0));
    tbl.push_back(mk(0,1,32'h4444_4444,1,32'h500,1, 1,32'h500, 0,32'h0,32'h0));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,1, 0,32'h0,  0,32'h0,32'h0));
    tbl.push_back(mk(0,1,32'h5050_5050,0,32'h0,1, 0,32'h0, 1,32'h500,32'h5050_5050));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'h504, 0,32'h0,32'h0));

    tick();
    rst = 1'b0;
    chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    foreach (tbl[i]) begin
      imem_req_ready = tbl[i].rdy;
      imem_rsp_valid = tbl[i].rsp;
      imem_rsp_data  = tbl[i].data;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      out_ready      = tbl[i].ordy;
      tick();
      chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_out_instr", i), out_instr, tbl[i].e_instr);
      end
    end

    // ---------------- redirect while holding, then PC wrap ----------------
    do_reset();
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("hold_first_req", 32'(imem_req_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'hC;
    tick();
    redirect_valid = 1'b0;
    chk("hold_retarget", imem_req_addr, 32'hC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'hC);
    tick();
    imem_rsp_valid = 1'b0;
    chk("hold_pc_c", out_pc, 32'hC);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("hold_redir_ov", 32'(out_valid), 32'd0);
    chk("hold_redir_addr", imem_req_addr, 32'h40);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h40); out_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    chk("hold_pc_40", out_pc, 32'h40);
    tick();
    chk("hold_next_addr", imem_req_addr, 32'h44);

    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1'b0;
    chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    out_ready = 1'b1;
    tick();
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    chk("wrap_next_addr", imem_req_addr, 32'h0);

    // ---------------- reset with a dropped request in flight ----------------
    out_ready = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    do_reset();
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("midrst_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h0);
    tick();
    imem_rsp_valid = 1'b0;
    chk("midrst_delivered", 32'(out_valid), 32'd1);
    chk("midrst_out_pc", out_pc, 32'h0);

`ifdef FETCH_STATS_EN
    // ---------------- statistics counters ----------------
    do_reset();
    chk("stats_rst_fetch", 32'(fetch_count), 32'd0);
    chk("stats_rst_stall", 32'(stall_cycles), 32'd0);
    deliver(4, 32'hA);
    deliver(0, 32'hB);
    deliver(0, 32'hC);
    chk("stats_fetch", 32'(fetch_count), 32'd3);
    chk("stats_stall", 32'(stall_cycles), 32'd4);
    do_reset();
    chk("stats_clr_fetch", 32'(fetch_count), 32'd0);
    chk("stats_clr_stall", 32'(stall_cycles), 32'd0);
`endif

    // ---------------- random traffic vs. transaction model ----------------
    do_reset();
    exp_next   = 32'h0;
    pending    = 1'b0;
    paddr      = 32'h0;
    lat        = 0;
    deliveries = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      c_rdy   = ($urandom % 4) != 0;
      c_ordy  = ($urandom % 3) != 0;
      c_redir = ($urandom % 12) == 0;
      c_rpc   = (($urandom % 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      c_rsp   = pending && (lat == 0);
      imem_req_ready = c_rdy;
      out_ready      = c_ordy;
      redirect_valid = c_redir;
      redirect_pc    = c_rpc;
      imem_rsp_valid = c_rsp;
      imem_rsp_data  = mem_word(paddr);
      p_rv = imem_req_valid; p_addr = imem_req_addr;
      p_ov = out_valid; p_pc = out_pc; p_instr = out_instr;
      tick();

      pend0 = pending;
      if (c_rsp) pending = 1'b0;
      else if (pending && lat > 0) lat--;

      if (p_rv && c_rdy) begin
        chk("rnd_one_outstanding", 32'(pend0), 32'd0);
        chk("rnd_req_addr", p_addr, exp_next);
        pending = 1'b1;
        paddr   = p_addr;
        lat     = int'($urandom % 3);
      end
      if (p_ov && c_ordy) begin
        chk("rnd_out_pc", p_pc, exp_next);
        chk("rnd_out_instr", p_instr, mem_word(p_pc));
        exp_next = p_pc + 32'd4;
        deliveries++;
      end
      if (c_redir) begin
        exp_next = c_rpc;
        chk("rnd_redir_clears", 32'(out_valid), 32'd0);
      end else begin
        if (p_ov && !c_ordy) begin
          chk("rnd_hold_valid", 32'(out_valid), 32'd1);
          chk("rnd_hold_pc", out_pc, p_pc);
          chk("rnd_hold_instr", out_instr, p_instr);
        end
        if (p_rv && !c_rdy) begin
          chk("rnd_req_stable_v", 32'(imem_req_valid), 32'd1);
          chk("rnd_req_stable_a", imem_req_addr, p_addr);
        end
      end
    end
    chk("rnd_progress", 32'(deliveries > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
